fetch_stream: RTL and testbench

FETCH_STREAM -- requirements
Module: fetch_stream

---
 rtl/fetch_stream.sv | 165 ++++++++++++++++
 tb/tb_fetch_stream.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stream.sv
// Line-based instruction fetch: issues line reads, discards stale responses after a redirect,
// and presents a byte window of the fetched stream to the decoder.
module fetch_stream #(
    parameter int IADDRW = 32,
    parameter int LINEB  = 16,
    parameter int MAXOUT = 4,
    parameter int QLINES = 4,
    parameter int OUTB   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    load,
    input  logic [IADDRW-1:0]       load_address,
    output logic                    imem_valid,
    input  logic                    imem_ready,
    output logic [IADDRW-1:0]       imem_address,
    input  logic                    imem_dp_valid,
    output logic                    imem_dp_ready,
    input  logic [8*LINEB-1:0]      imem_dp_read_data,
    output logic                    f_valid,
    input  logic                    f_ready,
    input  logic [$clog2(OUTB):0]   f_bytes_read,
    output logic [$clog2(OUTB):0]   f_valid_bytes,
    output logic [8*OUTB-1:0]       f_instruction,
    output logic [IADDRW-1:0]       f_pc,
    output logic [$clog2(MAXOUT):0] f_drop_cnt
);

    localparam int LB  = $clog2(LINEB);
    localparam int QB  = QLINES * LINEB;
    localparam int QPW = $clog2(QB);
    localparam int CW  = QPW + 1;
    localparam int FBW = $clog2(OUTB) + 1;
    localparam int OW  = $clog2(MAXOUT) + 1;
    localparam int SW  = ((CW > OW) ? CW : OW) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [IADDRW-1:0] fetch_addr;
    logic [LB-1:0]     skip;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [QPW-1:0]    rd_ptr;
    logic              pend;
    logic [7:0]        qmem [QB];

    logic [SW-1:0]     occ;
    logic              req_acc;
    logic              dp_acc;
    logic              redirect;
    logic              enq;
    logic [FBW-1:0]    deq_n;
    logic [OW-1:0]     out_next;
    logic [CW-1:0]     count_next;
    logic [QPW-1:0]    rd_next;
    logic [QPW:0]      wr_base;

    function automatic logic [QPW-1:0] qwrap(input logic [QPW:0] s);
        if (s >= (QPW+1)'(QB)) return QPW'(s - (QPW+1)'(QB));
        return s[QPW-1:0];
    endfunction

    // Consumer over-reads are clipped to what the window actually holds.
    function automatic logic [FBW-1:0] sat_take(input logic [FBW-1:0] want,
                                                input logic [FBW-1:0] avail);
        return (want > avail) ? avail : want;
    endfunction

    assign imem_dp_ready = 1'b1;
    assign imem_address  = fetch_addr & ~IADDRW'(LINEB - 1);
    assign f_drop_cnt    = drop_cnt;

    always_comb begin
        // A partially filled line still reserves a whole line of space.
        occ        = SW'(outstanding) + SW'(count[CW-1:LB]) + SW'(count[LB-1:0] != '0);
        imem_valid = (state == RUN) &&
                     (pend || ((occ < SW'(QLINES)) && (outstanding < OW'(MAXOUT))));
        req_acc    = imem_valid && imem_ready;
        dp_acc     = imem_dp_valid && imem_dp_ready;
        redirect   = flush || load;
        out_next   = outstanding + OW'(req_acc) - OW'(dp_acc);
        enq        = dp_acc && (drop_cnt == '0) && !redirect;

        f_valid_bytes = (count > CW'(OUTB)) ? FBW'(OUTB) : FBW'(count);
        f_valid       = (f_valid_bytes != '0);
        deq_n         = (f_valid && f_ready && !redirect) ? sat_take(f_bytes_read, f_valid_bytes) : '0;

        count_next = count + (enq ? (CW'(LINEB) - CW'(skip)) : '0) - CW'(deq_n);
        rd_next    = qwrap((QPW+1)'(rd_ptr) + (QPW+1)'(deq_n));
        wr_base    = (QPW+1)'(qwrap((QPW+1)'(rd_ptr) + (QPW+1)'(count)));
    end

    always_comb begin
        for (int i = 0; i < OUTB; i++) begin
            f_instruction[8*i +: 8] = qmem[qwrap((QPW+1)'(rd_ptr) + (QPW+1)'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < LINEB; i++) begin
                if (i >= int'(skip)) begin
                    qmem[qwrap(wr_base + (QPW+1)'(i - int'(skip)))] <= imem_dp_read_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            f_pc        <= '0;
            skip        <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            pend        <= 1'b0;
        end else begin
            if (load)
                state <= RUN;
            else if (flush)
                state <= IDLE;

            pend <= redirect ? 1'b0 : (imem_valid && !imem_ready);

            if (load)
                fetch_addr <= load_address;
            else if (req_acc)
                fetch_addr <= fetch_addr + IADDRW'(LINEB);

            outstanding <= out_next;

            // Everything still in flight at a redirect belongs to the old stream.
            if (redirect)
                drop_cnt <= out_next;
            else if (dp_acc && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;

            if (load)
                skip <= load_address[LB-1:0];
            else if (enq)
                skip <= '0;

            if (load)
                f_pc <= load_address;
            else if (deq_n != '0)
                f_pc <= f_pc + IADDRW'(deq_n);

            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                count  <= count_next;
                rd_ptr <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stream.sv
// Directed bench for fetch_stream: memory model plus request and consume scoreboards.
module tb_fetch_stream;

    localparam int IADDRW = 32;
    localparam int LINEB  = 16;
    localparam int MAXOUT = 4;
    localparam int QLINES = 4;
    localparam int OUTB   = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic                    load;
    logic [IADDRW-1:0]       load_address;
    logic                    imem_valid;
    logic                    imem_ready;
    logic [IADDRW-1:0]       imem_address;
    logic                    imem_dp_valid;
    logic                    imem_dp_ready;
    logic [8*LINEB-1:0]      imem_dp_read_data;
    logic                    f_valid;
    logic                    f_ready;
    logic [$clog2(OUTB):0]   f_bytes_read;
    logic [$clog2(OUTB):0]   f_valid_bytes;
    logic [8*OUTB-1:0]       f_instruction;
    logic [IADDRW-1:0]       f_pc;
    logic [$clog2(MAXOUT):0] f_drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    logic [7:0]  exp_b0[$];

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          lat = 0;
    logic        snap_req = 1'b0;
    logic        snap_dp = 1'b0;
    logic [31:0] snap_addr = '0;

    fetch_stream #(
        .IADDRW(IADDRW), .LINEB(LINEB), .MAXOUT(MAXOUT), .QLINES(QLINES), .OUTB(OUTB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .load(load), .load_address(load_address),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_address(imem_address),
        .imem_dp_valid(imem_dp_valid), .imem_dp_ready(imem_dp_ready),
        .imem_dp_read_data(imem_dp_read_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_bytes_read(f_bytes_read),
        .f_valid_bytes(f_valid_bytes), .f_instruction(f_instruction), .f_pc(f_pc),
        .f_drop_cnt(f_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8*LINEB-1:0] line_of(input logic [31:0] a);
        logic [8*LINEB-1:0] r;
        logic [31:0]        b;
        r = '0;
        for (int i = 0; i < LINEB; i++) begin
            b = a + 32'(i);
            r[8*i +: 8] = b[7:0] ^ b[15:8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: requests and consumer accepts.
    always @(negedge clk) begin
        snap_req  = imem_valid && imem_ready;
        snap_addr = imem_address;
        snap_dp   = imem_dp_valid && imem_dp_ready;
        if (!reset && imem_valid && imem_ready) begin
            if (exp_req.size() == 0) fail_now("req_unexpected");
            else chk("req_addr", imem_address, exp_req.pop_front());
        end
        if (!reset && f_valid && f_ready) begin
            if (exp_pc.size() == 0) fail_now("consume_unexpected");
            else begin
                chk("consume_pc", f_pc, exp_pc.pop_front());
                chk("consume_byte0", f_instruction[7:0], exp_b0.pop_front());
            end
        end
    end

    // Memory model: in-order responses, lat cycles after the accepting edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            imem_dp_valid = 1'b0;
        end else begin
            if (snap_dp && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (snap_req) begin
                mq_addr.push_back(snap_addr);
                mq_due.push_back(cyc + lat);
            end
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_dp_valid     = 1'b1;
                imem_dp_read_data = line_of(mq_addr[0]);
            end else begin
                imem_dp_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_d;
        int budget;
        reset = 1'b1; flush = 1'b0; load = 1'b0; load_address = '0;
        imem_ready = 1'b1; f_ready = 1'b0; f_bytes_read = '0;
        imem_dp_valid = 1'b0; imem_dp_read_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_valid", imem_valid, 0);
        chk("rst_imem_address", imem_address, 0);
        chk("rst_f_pc", f_pc, 0);
        chk("rst_f_valid", f_valid, 0);
        chk("rst_f_valid_bytes", f_valid_bytes, 0);
        chk("rst_drop_cnt", f_drop_cnt, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_no_request", imem_valid, 0);

        // Unaligned load, zero-latency memory, consumer stalled.
        lat = 0;
        exp_req.push_back(32'h1000); exp_req.push_back(32'h1010);
        exp_req.push_back(32'h1020); exp_req.push_back(32'h1030);
        load = 1'b1; load_address = 32'h1003;
        tick();
        load = 1'b0;
        chk("load_f_pc", f_pc, 32'h1003);
        chk("load_fvb", f_valid_bytes, 0);
        chk("load_imem_address", imem_address, 32'h1000);
        tick();
        tick();
        chk("fvb_13", f_valid_bytes, 13);
        chk("byte0_1003", f_instruction[7:0], 8'h13);
        tick();
        chk("fvb_29", f_valid_bytes, 29);
        chk("byte12_100f", f_instruction[103:96], 8'h1F);
        chk("byte13_1010", f_instruction[111:104], 8'h00);
        tick();
        chk("fvb_32", f_valid_bytes, 32);
        chk("byte31_1022", f_instruction[255:248], 8'h32);
        repeat (4) tick();
        chk("full_no_request", imem_valid, 0);

        exp_req.push_back(32'h1040);
        exp_pc.push_back(32'h1003); exp_b0.push_back(8'h13);
        exp_pc.push_back(32'h1008); exp_b0.push_back(8'h18);
        exp_pc.push_back(32'h100D); exp_b0.push_back(8'h1D);
        f_bytes_read = 5; f_ready = 1'b1;
        repeat (3) tick();
        f_ready = 1'b0;
        chk("pc_after_15", f_pc, 32'h1012);
        repeat (6) tick();

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_drop", f_drop_cnt, 0);

        // Flush + load with three reads in flight, 3-cycle memory.
        lat = 3;
        exp_req.push_back(32'h3000); exp_req.push_back(32'h3010); exp_req.push_back(32'h3020);
        exp_req.push_back(32'h2000); exp_req.push_back(32'h2010);
        exp_req.push_back(32'h2020); exp_req.push_back(32'h2030);
        load = 1'b1; load_address = 32'h3000;
        tick();
        load = 1'b0;
        tick();
        tick();
        flush = 1'b1; load = 1'b1; load_address = 32'h2000;
        tick();
        flush = 1'b0; load = 1'b0;
        chk("drop_after_flush", f_drop_cnt, 3);
        chk("fvalid_after_flush", f_valid, 0);
        exp_d = 3;
        budget = 0;
        while (exp_d > 0 && budget < 20) begin
            tick();
            budget++;
            if (int'(f_drop_cnt) != exp_d) begin
                exp_d--;
                chk("drop_step", f_drop_cnt, 64'(exp_d));
                chk("fvalid_while_drop", f_valid, 0);
            end
        end
        if (exp_d != 0) fail_now("drop_timeout");
        budget = 0;
        while (!f_valid && budget < 20) begin
            tick();
            budget++;
        end
        if (!f_valid) fail_now("first_line_timeout");
        chk("new_stream_pc", f_pc, 32'h2000);
        chk("new_stream_byte0", f_instruction[7:0], 8'h20);
        chk("new_stream_fvb", f_valid_bytes, 16);
        repeat (10) tick();
        chk("backpressure_no_req", imem_valid, 0);

        // All four lines must be held: drain 64 bytes without refetching.
        imem_ready = 1'b0;
        exp_pc.push_back(32'h2000); exp_b0.push_back(8'h20);
        f_bytes_read = 32; f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        chk("second_half_fvb", f_valid_bytes, 32);
        chk("second_half_byte0", f_instruction[7:0], 8'h00);
        exp_pc.push_back(32'h2020); exp_b0.push_back(8'h00);
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        chk("drained_fvb", f_valid_bytes, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        imem_ready = 1'b1;

        // Request, response and flush in one cycle with two outstanding.
        lat = 1;
        exp_req.push_back(32'h4000); exp_req.push_back(32'h4010); exp_req.push_back(32'h4020);
        load = 1'b1; load_address = 32'h4000;
        tick();
        load = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("triple_drop", f_drop_cnt, 2);
        chk("triple_fvalid", f_valid, 0);
        tick();
        chk("triple_drop_1", f_drop_cnt, 1);
        tick();
        chk("triple_drop_0", f_drop_cnt, 0);
        chk("triple_idle", imem_valid, 0);
        repeat (3) tick();

        // Address wrap around 2^32.
        lat = 0;
        exp_req.push_back(32'hFFFF_FFF0); exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0010); exp_req.push_back(32'h0000_0020);
        load = 1'b1; load_address = 32'hFFFF_FFF8;
        tick();
        load = 1'b0;
        repeat (8) tick();
        chk("wrap_fvb", f_valid_bytes, 32);
        chk("wrap_pc", f_pc, 32'hFFFF_FFF8);
        imem_ready = 1'b0;
        exp_pc.push_back(32'hFFFF_FFF8); exp_b0.push_back(8'h07);
        f_bytes_read = 8; f_ready = 1'b1;
        tick();
        chk("wrap_pc_1", f_pc, 32'h0000_0000);
        exp_pc.push_back(32'h0000_0000); exp_b0.push_back(8'h00);
        tick();
        chk("wrap_pc_2", f_pc, 32'h0000_0008);
        exp_pc.push_back(32'h0000_0008); exp_b0.push_back(8'h08);
        f_bytes_read = 16;
        tick();
        chk("wrap_pc_3", f_pc, 32'h0000_0018);
        chk("wrap_fvb_24", f_valid_bytes, 24);
        exp_pc.push_back(32'h0000_0018); exp_b0.push_back(8'h18);
        f_bytes_read = 40;
        tick();
        f_ready = 1'b0;
        chk("sat_pc", f_pc, 32'h0000_0030);
        chk("sat_fvalid", f_valid, 0);
        chk("hold_valid", imem_valid, 1);
        chk("hold_addr", imem_address, 32'h0000_0030);
        tick();
        chk("hold_addr_2", imem_address, 32'h0000_0030);

        // Asynchronous reset in the middle of a burst.
        exp_req.push_back(32'h0000_0030); exp_req.push_back(32'h0000_0040);
        imem_ready = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_imem_valid", imem_valid, 0);
        chk("async_imem_address", imem_address, 0);
        chk("async_f_pc", f_pc, 0);
        chk("async_f_valid", f_valid, 0);
        chk("async_fvb", f_valid_bytes, 0);
        chk("async_drop", f_drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        chk("post_reset_idle", imem_valid, 0);
        chk("post_reset_pc", f_pc, 0);
        chk("req_queue_drained", exp_req.size(), 0);
        chk("consume_queue_drained", exp_pc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
